// File: rtl/spi_regfile_resp.sv
// rtl/spi_regfile_resp.sv - serial frame responder writing/reading a DEPTH x DATA_W register file
module spi_regfile_resp #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cs_i,
    input  logic              sdi_i,
    output logic              sdo_o,
    output logic              ready_o,
    output logic              op_done_o,
    output logic              err_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OPCODE = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_READY  = 3'd5;
    localparam logic [2:0] S_RDATA  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] dbg_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic in_range;
    logic dbg_in_range;
    logic rd_last;

    // Full-width unsigned compare: addresses beyond DEPTH never alias onto low words
    assign in_range     = (32'(addr_q) < DEPTH);
    assign dbg_in_range = (32'(dbg_addr_i) < DEPTH);
    assign rd_last      = (cnt_q == CNT_W'(DATA_W));

    // Next-state and datapath shifting; cs only aborts while the frame is still being received
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!cs_i) state_d = S_OPCODE;
            end
            S_OPCODE: begin
                if (cs_i) begin
                    state_d = S_IDLE;
                end else begin
                    op_d    = sdi_i;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cs_i) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = {sdi_i, addr_q[ADDR_W-1:1]};
                    if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                        cnt_d   = '0;
                        state_d = op_q ? S_WDATA : S_READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (cs_i) begin
                    state_d = S_IDLE;
                end else begin
                    data_d = {sdi_i, data_q[DATA_W-1:1]};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = S_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            S_READY: begin
                rd_d    = in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;
                cnt_d   = '0;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (rd_last) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rd_d  = rd_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame state and shift registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    // Register file: single write port, committed only from a completed in-range write frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == S_COMMIT && in_range) begin
            mem_q[addr_q[IDX_W-1:0]] <= data_q;
        end
    end

    // Debug read port, registered with no write bypass
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_in_range ? mem_q[dbg_addr_i[IDX_W-1:0]] : '0;
        end
    end

    assign dbg_data_o = dbg_q;
    assign ready_o    = (state_q == S_READY);
    assign sdo_o      = (state_q == S_RDATA) && !rd_last && rd_q[0];
    assign op_done_o  = (state_q == S_COMMIT) || ((state_q == S_RDATA) && rd_last);
    assign err_o      = op_done_o && !in_range;

endmodule

// File: tb/tb_spi_regfile_resp.sv
// tb/tb_spi_regfile_resp.sv - self-checking bench for spi_regfile_resp
module tb_spi_regfile_resp;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       sdi;
    logic       sdo;
    logic       ready;
    logic       op_done;
    logic       err;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       is_read;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic       op;
        logic [7:0] addr;
        logic [7:0] data;
        logic       early_cs;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_rd;
        logic       dchk;
        logic [7:0] daddr;
        logic [7:0] dexp;
    } vec_t;

    vec_t tbl[13];

    spi_regfile_resp dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cs_i       (cs),
        .sdi_i      (sdi),
        .sdo_o      (sdo),
        .ready_o    (ready),
        .op_done_o  (op_done),
        .err_o      (err),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic dbg_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        dbg_addr = a;
        @(negedge clk);
        chk(name, 32'(dbg_data), 32'(exp));
    endtask

    task automatic watch_quiet(input string name, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulses += int'(op_done) + int'(err) + int'(ready);
        end
        chk(name, 32'(pulses), 32'd0);
    endtask

    // Drive one complete frame; expectation is queued at drive time and popped when op_done appears
    task automatic run_frame(input vec_t v);
        exp_t       e;
        exp_t       got_e;
        int         lat = 0;
        int         rdy_lat = 0;
        int         k = 0;
        logic       collecting = 1'b0;
        logic       done = 1'b0;
        logic       got_err = 1'b0;
        logic [7:0] word = 8'h00;
        e.is_read = !v.op;
        e.err     = v.exp_err;
        e.rdata   = v.exp_rd;
        sb_q.push_back(e);
        @(negedge clk);
        cs  = 1'b0;
        sdi = 1'b0;
        @(negedge clk);
        sdi = v.op;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sdi = v.addr[i];
        end
        if (v.op) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                sdi = v.data[i];
            end
        end
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            if (v.early_cs) cs = 1'b1;
            if (ready) begin
                rdy_lat    = lat;
                collecting = 1'b1;
                k          = 0;
            end else if (collecting && k < 8) begin
                word[k] = sdo;
                k++;
            end
            if (op_done) begin
                done    = 1'b1;
                got_err = err;
                cs      = (v.gap == 0) ? 1'b0 : 1'b1;
            end
        end
        chk("frame_done_seen", 32'(done), 32'd1);
        if (done && sb_q.size() > 0) begin
            got_e = sb_q.pop_front();
            chk("frame_err", 32'(got_err), 32'(got_e.err));
            if (got_e.is_read) begin
                chk("read_ready_latency", 32'(rdy_lat), 32'd1);
                chk("read_done_latency", 32'(lat), 32'd10);
                chk("read_bits", 32'(k), 32'd8);
                chk("read_word", 32'(word), 32'(got_e.rdata));
            end else begin
                chk("write_done_latency", 32'(lat), 32'd1);
            end
        end
        for (int i = 0; i < v.gap; i++) @(negedge clk);
        if (v.dchk) dbg_chk("table_dbg", v.daddr, v.dexp);
    endtask

    function automatic vec_t mk(input logic op, input logic [7:0] a, input logic [7:0] d,
                                input logic early, input int gap, input logic e_err,
                                input logic [7:0] e_rd, input logic dc, input logic [7:0] da,
                                input logic [7:0] de);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.early_cs = early; v.gap = gap;
        v.exp_err = e_err; v.exp_rd = e_rd; v.dchk = dc; v.daddr = da; v.dexp = de;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   n;

        //         op    addr   data   early gap err   rdata  dbg   daddr  dexp
        tbl[0]  = mk(1'b1, 8'h05, 8'hA5, 1'b0, 2, 1'b0, 8'h00, 1'b1, 8'h05, 8'hA5);
        tbl[1]  = mk(1'b0, 8'h05, 8'h00, 1'b0, 2, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00);
        tbl[2]  = mk(1'b1, 8'h20, 8'hFF, 1'b0, 2, 1'b1, 8'h00, 1'b1, 8'h00, 8'h00);
        tbl[3]  = mk(1'b0, 8'h20, 8'h00, 1'b1, 2, 1'b1, 8'h00, 1'b1, 8'h1F, 8'h00);
        tbl[4]  = mk(1'b1, 8'h1F, 8'h3C, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[5]  = mk(1'b1, 8'h00, 8'hC3, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[6]  = mk(1'b0, 8'h1F, 8'h00, 1'b0, 0, 1'b0, 8'h3C, 1'b0, 8'h00, 8'h00);
        tbl[7]  = mk(1'b0, 8'h00, 8'h00, 1'b1, 2, 1'b0, 8'hC3, 1'b0, 8'h00, 8'h00);
        tbl[8]  = mk(1'b1, 8'hFF, 8'h12, 1'b0, 1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[9]  = mk(1'b0, 8'h1F, 8'h00, 1'b0, 1, 1'b0, 8'h3C, 1'b0, 8'h00, 8'h00);
        tbl[10] = mk(1'b0, 8'h3F, 8'h00, 1'b0, 1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[11] = mk(1'b1, 8'h05, 8'h5A, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        tbl[12] = mk(1'b0, 8'h05, 8'h00, 1'b0, 3, 1'b0, 8'h5A, 1'b0, 8'h00, 8'h00);

        rst_n    = 1'b0;
        cs       = 1'b1;
        sdi      = 1'b0;
        dbg_addr = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_sdo", 32'(sdo), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_op_done", 32'(op_done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_dbg", 32'(dbg_data), 32'd0);

        for (int i = 0; i < 13; i++) run_frame(tbl[i]);

        dbg_chk("dbg_05", 8'h05, 8'h5A);
        dbg_chk("dbg_00", 8'h00, 8'hC3);
        dbg_chk("dbg_1f", 8'h1F, 8'h3C);
        dbg_chk("dbg_20_oor", 8'h20, 8'h00);
        dbg_chk("dbg_ff_oor", 8'hFF, 8'h00);

        // Abort during address: cs rises after 6 address bits
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        sdi = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sdi = i[0] ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        cs = 1'b1;
        watch_quiet("abort_addr_quiet", 20);
        dbg_chk("abort_addr_mem3", 8'h03, 8'h00);

        // Abort during write data after 4 data bits
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        sdi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sdi = (i < 2) ? 1'b1 : 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sdi = 1'b1;
        end
        @(negedge clk);
        cs = 1'b1;
        watch_quiet("abort_wdata_quiet", 20);
        dbg_chk("abort_wdata_mem3", 8'h03, 8'h00);

        // Abort in opcode cycle
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        cs  = 1'b1;
        sdi = 1'b1;
        watch_quiet("abort_op_quiet", 12);

        v = mk(1'b1, 8'h03, 8'h77, 1'b0, 1, 1'b0, 8'h00, 1'b1, 8'h03, 8'h77);
        run_frame(v);
        v = mk(1'b0, 8'h03, 8'h00, 1'b0, 1, 1'b0, 8'h77, 1'b0, 8'h00, 8'h00);
        run_frame(v);

        // Reset in the middle of a read of 0x1F (0x3C), while sdo is driving a 1
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        sdi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sdi = (i < 5) ? 1'b1 : 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 5);
        chk("rst_read_ready_seen", 32'(ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_read_sdo_before", 32'(sdo), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_sdo", 32'(sdo), 32'd0);
        chk("rst_async_ready", 32'(ready), 32'd0);
        chk("rst_async_op_done", 32'(op_done), 32'd0);
        chk("rst_async_dbg", 32'(dbg_data), 32'd0);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rst_release_quiet", 20);
        dbg_chk("rst_mem_1f", 8'h1F, 8'h00);
        dbg_chk("rst_mem_05", 8'h05, 8'h00);
        dbg_chk("rst_mem_03", 8'h03, 8'h00);

        v = mk(1'b0, 8'h00, 8'h00, 1'b0, 1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
        run_frame(v);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
